// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the dual-clock FIFO: issues reads, lands returning words
// in a 2-entry skid buffer and presents them as a valid/ready stream.
module fifo_rd_stream #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned CNTW   = 16
) (
    input  logic              clkr,
    input  logic              rst,
    input  logic              flush,
    input  logic              notempty,
    input  logic              read,
    output logic              fiford,
    input  logic [DWIDTH-1:0] rddata,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready,
    output logic [1:0]        occ,
    output logic [CNTW-1:0]   wordcnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t              state;
    occ_t              state_nxt;
    logic [DWIDTH-1:0] head;
    logic [DWIDTH-1:0] tail;
    logic [DWIDTH-1:0] head_nxt;
    logic [DWIDTH-1:0] tail_nxt;
    logic              inflight;
    logic              discard;
    logic              pop;
    logic              push;
    logic [2:0]        pending;

    assign m_valid = (state != EMPTY);
    assign m_data  = head;
    assign occ     = 2'(state);
    assign pop     = m_valid & m_ready;
    assign push    = inflight & ~discard & ~flush;

    // Request only when the word would have a guaranteed slot after this cycle's pop
    assign pending = 3'(occ) + 3'(inflight) - 3'(pop);
    assign fiford  = notempty & ~flush & ~rst & (pending < 3'd2);

    always_ff @(posedge clkr or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
            wordcnt  <= '0;
        end else begin
            state    <= state_nxt;
            head     <= head_nxt;
            tail     <= tail_nxt;
            inflight <= read & ~flush;
            discard  <= flush & inflight;
            if (pop) begin
                wordcnt <= wordcnt + CNTW'(1);
            end
        end
    end

    // Occupancy FSM; head always holds the oldest word
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_nxt  = rddata;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt = FULL;
                    tail_nxt  = rddata;
                end else if (pop && !push) begin
                    state_nxt = EMPTY;
                end else if (push && pop) begin
                    head_nxt = rddata;
                end
            end
            FULL: begin
                if (pop) begin
                    head_nxt = tail;
                    if (push) begin
                        tail_nxt = rddata;
                    end else begin
                        state_nxt = ONE;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    a_no_overflow: assert property (@(posedge clkr) disable iff (rst)
        !(push && (state == FULL) && !pop));

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer stage for the dual-clock FIFO controller. It runs in the clkr domain and issues fiford whenever the FIFO is not empty and a landing slot is guaranteed. It captures memory read data one cycle after each granted read and presents it as a valid/ready stream. A 2-entry skid buffer sustains one word per clkr cycle under continuous m_ready, and applies backpressure without losing data.

Parameters:
DWIDTH, 8, width of memory read data and stream data
CNTW, 16, width of delivered-word counter

Ports:
clkr  in  1  read-domain clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous discard of buffered and in-flight data
notempty  in  1  FIFO controller not-empty flag
read  in  1  FIFO controller granted read (fiford & !empty); memory data follows next cycle
fiford  out  1  read request to FIFO controller
rddata  in  DWIDTH  memory read data, valid the cycle after read
m_valid  out  1  stream data valid
m_data  out  DWIDTH  stream data (buffer head)
m_ready  in  1  downstream accept
occ  out  2  buffer occupancy 0..2
wordcnt  out  CNTW  count of accepted transfers (m_valid & m_ready)

Behaviour:
- Reset (async, rst=1): occ=0, inflight=0, m_valid=0, m_data=0, wordcnt=0. fiford=0 while rst is high.
- Internal state:
  - 2-entry buffer (head, tail) with occ.
  - inflight flag = registered read & !flush.
  - discard flag, set on flush while inflight=1.
- pop = m_valid & m_ready. push = inflight & !discard & !flush.
- fiford is combinational: notempty & !flush & !rst & ((occ + inflight - pop) < 2).
  - Steady state occ=1, inflight=1, pop=1 keeps requesting, giving full throughput.
  - With no pop at occ=1, inflight=1, fiford=0.
  - Overflow is structurally impossible. A push when occ=2 and pop=0 is an assertion failure.
- Occupancy states:
  - EMPTY (occ=0): push -> ONE. m_valid=0.
  - ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop -> ONE, and the new word becomes head.
  - FULL: pop -> ONE, tail moves to head. push & pop -> FULL.
- Ordering: strict FIFO. The word captured first is presented first.
- m_valid = (occ != 0). m_data = head register. m_data holds stable while m_valid & !m_ready.
- Latency: read high in cycle t -> rddata captured at end of t+1 -> m_valid high in t+2 (when the buffer was empty).
- wordcnt increments on each pop and wraps modulo 2^CNTW. Cleared only by rst, not by flush.
- Flush (one cycle):
  - Next cycle: occ=0, m_valid=0.
  - fiford=0 during the flush cycle.
  - Any word returning in the cycle after a pre-flush read is dropped via discard. discard clears after that cycle.
  - pop in the flush cycle still counts in wordcnt.
- notempty falling while inflight=1: the in-flight word is still captured.
- read without a preceding fiford is treated as a granted read and captured.
- rst asserted mid-stream: immediate clear of all state; in-flight data is lost.

Test Plan:
- Reset then idle, notempty=0 -> fiford=0, m_valid=0, occ=0, wordcnt=0 for 10 cycles.
- FIFO holds 0x11,0x22,0x33, m_ready=1 constantly -> first m_valid 2 cycles after first read; 0x11,0x22,0x33 on consecutive cycles; wordcnt=3; fiford low once notempty drops.
- 8 words queued, m_ready=0 -> exactly 2 reads issued, occ=2, fiford=0, m_data=word0 stable; then m_ready=1 -> all 8 delivered in order with no gaps after restart.
- m_ready toggling 1,0,1,0 with 6 words queued -> no loss or duplication; order preserved; wordcnt=6; occ never exceeds 2.
- flush asserted the cycle after a read, with occ=1 -> next cycle occ=0, m_valid=0; returning word dropped; next read delivers the following FIFO word.
- rst pulsed while occ=2 and inflight=1 -> all outputs return to reset values asynchronously; no stale word appears after rst is released.
